// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a bounded grant length.
// A grant ends when the grantee is done, drops its request, or reaches MAX_HOLD cycles.
module rr_arbiter4 #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req_i,
   input  logic       done_i,
   output logic [3:0] grant_o,
   output logic [1:0] grant_id_o,
   output logic       busy_o,
   output logic       any_req_o,
   output logic       timeout_o
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
   logic [3:0]       grant_q, grant_d;
   logic [1:0]       grantId_q, grantId_d;
   logic             busy_q, busy_d;
   logic             timeout_q, timeout_d;

   logic [1:0]       winner;
   logic [1:0]       searchIdx;
   logic             found;
   logic             relDone;
   logic             relDrop;
   logic             relLimit;

   assign any_req_o = |req_i;

   // First requester found walking upward from the priority pointer.
   always_comb begin
      winner    = ptr_q;
      searchIdx = ptr_q;
      found     = 1'b0;
      for (int k = 0; k < 4; k++) begin
         searchIdx = ptr_q + 2'(k);
         if (!found && req_i[searchIdx]) begin
            winner = searchIdx;
            found  = 1'b1;
         end
      end
   end

   assign relDone  = done_i;
   assign relDrop  = ~req_i[grantId_q];
   assign relLimit = (holdCnt_q == CNT_W'(MAX_HOLD - 1));

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      holdCnt_d = holdCnt_q;
      grant_d   = grant_q;
      grantId_d = grantId_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req_o) begin
               grant_d   = 4'b0001 << winner;
               grantId_d = winner;
               busy_d    = 1'b1;
               holdCnt_d = '0;
               state_d   = GRANT;
            end
         end
         GRANT: begin
            holdCnt_d = holdCnt_q + CNT_W'(1);
            // Timeout is flagged only when the hold limit alone ends the grant.
            if (relDone || relDrop || relLimit) begin
               grant_d   = '0;
               busy_d    = 1'b0;
               ptr_d     = grantId_q + 2'd1;
               state_d   = IDLE;
               timeout_d = relLimit & ~relDone & ~relDrop;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         holdCnt_q <= '0;
         grant_q   <= '0;
         grantId_q <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         holdCnt_q <= holdCnt_d;
         grant_q   <= grant_d;
         grantId_q <= grantId_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant_o    = grant_q;
   assign grant_id_o = grantId_q;
   assign busy_o     = busy_q;
   assign timeout_o  = timeout_q;

endmodule
